// File: rtl/sv_clk_div_pkg.sv
// Shared state encoding and phase helper for the programmable clock divider.
package sv_clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   // An N-cycle period is low for ceil(N/2) cycles, then high for floor(N/2).
   function automatic int unsigned low_phase(input int unsigned n);
      return n - n / 2;
   endfunction

endpackage

// File: rtl/sv_div_phase_counter.sv
// Period counter with registered clk_out/rise_tick derived from the next count,
// so both outputs line up with the count they describe.
module sv_div_phase_counter #(
   parameter int CNT_W = 9
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             run,
   input  logic             load_zero,
   input  logic [CNT_W-1:0] div,
   output logic             boundary,
   output logic             clk_out,
   output logic             rise_tick
);
   import sv_clk_div_pkg::*;

   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_rise_tick;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_low;

   // div only changes when the count restarts at 0, which is below any low
   // phase, so using the current ratio for the next-count compare is exact.
   assign w_low    = CNT_W'(low_phase(32'(div)));
   assign boundary = run && (r_cnt == div - CNT_W'(1));

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (load_zero) begin
         w_cnt_nxt = '0;
      end else if (run) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_cnt       <= '0;
         r_clk_out   <= 1'b0;
         r_rise_tick <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_clk_out   <= (w_cnt_nxt >= w_low);
         r_rise_tick <= (w_cnt_nxt == w_low);
      end
   end

   assign clk_out   = r_clk_out;
   assign rise_tick = r_rise_tick;

endmodule

// File: rtl/sv_clk_div_ctrl.sv
// Runtime-programmable clock divider: ratio changes and stops land on period
// boundaries; cfg_ready drops while a ratio change is waiting for the boundary.
module sv_clk_div_ctrl #(
   parameter  int MAX_DIV = 256,
   parameter  int DEF_DIV = 2,
   localparam int CNT_W   = $clog2(MAX_DIV + 1)
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             rise_tick,
   output logic             active,
   output logic [CNT_W-1:0] cur_div
);
   import sv_clk_div_pkg::*;

   if (DEF_DIV < 2 || DEF_DIV > MAX_DIV) begin : g_bad_def_div
      $error("sv_clk_div_ctrl: DEF_DIV must lie in [2, MAX_DIV]");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cur_div;
   logic [CNT_W-1:0] r_pend_div;
   logic [CNT_W-1:0] w_cur_div_nxt;
   logic [CNT_W-1:0] w_pend_div_nxt;
   logic             r_cfg_err;
   logic             w_xfer;
   logic             w_legal;
   logic             w_cfg_ok;
   logic             w_boundary;
   logic             w_load_zero;

   assign cfg_ready = (r_state != PEND);
   assign w_xfer    = cfg_valid && cfg_ready;
   assign w_legal   = (cfg_div >= CNT_W'(2)) && (cfg_div <= CNT_W'(MAX_DIV));
   assign w_cfg_ok  = w_xfer && w_legal;

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_div_nxt  = r_cur_div;
      w_pend_div_nxt = r_pend_div;
      w_load_zero    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_load_zero = 1'b1;
            if (w_cfg_ok) w_cur_div_nxt = cfg_div;
            if (en)       w_state_nxt   = RUN;
         end
         RUN: begin
            if (w_boundary) w_load_zero = 1'b1;
            // Stopping at this boundary: a ratio offered now simply becomes
            // the idle ratio, there is no period left to protect.
            if (w_boundary && !en) begin
               w_state_nxt = IDLE;
               if (w_cfg_ok) w_cur_div_nxt = cfg_div;
            end else if (w_cfg_ok) begin
               w_pend_div_nxt = cfg_div;
               w_state_nxt    = PEND;
            end
         end
         PEND: begin
            if (w_boundary) begin
               w_load_zero   = 1'b1;
               w_cur_div_nxt = r_pend_div;
               w_state_nxt   = en ? RUN : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cur_div  <= CNT_W'(DEF_DIV);
         r_pend_div <= CNT_W'(DEF_DIV);
         r_cfg_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_div  <= w_cur_div_nxt;
         r_pend_div <= w_pend_div_nxt;
         r_cfg_err  <= w_xfer && !w_legal;
      end
   end

   sv_div_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase (
      .clk_in    (clk_in),
      .reset     (reset),
      .run       (r_state != IDLE),
      .load_zero (w_load_zero),
      .div       (r_cur_div),
      .boundary  (w_boundary),
      .clk_out   (clk_out),
      .rise_tick (rise_tick)
   );

   assign cfg_err = r_cfg_err;
   assign active  = (r_state != IDLE);
   assign cur_div = r_cur_div;

endmodule
